ss_decoder: RTL and testbench
=============================

// Module: ss_decoder
// PURPOSE
//   Receive side of the multiplexed seven-segment display. Watches the active-low
//   anode/cathode buses from ss_controller, or from an external display driver, and
//   recovers the 16-bit hex value being shown. Each digit is captured once its pattern
//   has settled; a frame is reported when all four digits have been seen.
//   Used for on-board loopback self-check and as a bench monitor.
// PARAMETERS
//   SETTLE_CYCLES  4   consecutive identical samples required before a digit is captured (>=1)
//   TIMEOUT_BITS   20  width of the idle timer; stale after 2**TIMEOUT_BITS-1 cycles without capture
// PORTS
//   clk_i           in   1   single clock
//   reset_i         in   1   synchronous, active-high reset
//   anode_bits_i    in   4   digit enables, active-low; bit n = digit n = bin nibble n
//   cathode_bits_i  in   7   segments, active-low; [0]=a .. [6]=g
//   bin_o           out  16  last completed frame value
//   valid_o         out  1   1-cycle pulse: bin_o updated
//   stable_o        out  1   last two consecutive frames were equal
//   err_o           out  1   1-cycle pulse: settled pattern did not decode
//   stale_o         out  1   no capture within the timeout window
// BEHAVIOUR
//   - Interface timing: inputs must be synchronous to clk_i; both are registered once internally.
//   - Reset values: bin_o=0, valid_o=0, stable_o=0, err_o=0, stale_o=1.
//     Internally, seen[3:0]=0, state=IDLE, and all counters are 0.
//   - Valid sample: the registered anode has exactly one bit low. Otherwise (0, 2, 3 or 4 low)
//     -> IDLE, settle count cleared. This is not an error.
//   - FSM IDLE -> SETTLE: on a valid sample.
//   - FSM SETTLE: count++ while the {anode,cathode} sample equals the previous one.
//     On any change, count restarts at 1 (valid sample) or the FSM returns to IDLE.
//     When count==SETTLE_CYCLES, capture and go to CAPTURED.
//   - FSM CAPTURED: no further capture until the sample changes. Then SETTLE or IDLE as above.
//   - Capture latency: capture occurs SETTLE_CYCLES+1 edges after the pattern first appears
//     at the ports.
//   - Decode table (cathode hex, g..a, active-low) for 0..F:
//     40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E.
//     Any other pattern, including blank 7F, is invalid.
//   - Capture, decodable: shadow[d]<=nibble, seen[d]<=1.
//   - Capture, invalid: err_o pulses 1 cycle, seen[d]<=0, shadow unchanged.
//   - Frame complete: the capture makes seen==4'hF. On the next edge:
//     bin_o<={shadow3..0} with the new nibble included, valid_o=1 for 1 cycle,
//     seen<=0, stale_o<=0.
//     stable_o<=1 iff the new value equals the previous bin_o and the previous frame was
//     valid with no stale in between; otherwise stable_o<=0.
//   - A repeated digit before the frame completes overwrites shadow[d]; seen is unchanged.
//   - Timeout: the timer resets on every capture (valid or invalid) and increments otherwise.
//     At all-ones it saturates: stale_o<=1, stable_o<=0, seen<=0. bin_o holds.
//   - Simultaneous frame completion and timeout: completion wins and the timer clears.
//   - reset_i mid-frame: every register returns to its reset value on that edge;
//     partial digits are discarded.
// CONFIGURATION
//   SS_DECODER_ERR_CNT_EN defined:
//     - Adds output err_count_o [7:0], a saturating count of err_o pulses.
//     - Resets to 0 and holds at 255; it is not cleared by frames or by timeout.
//   SS_DECODER_ERR_CNT_EN undefined:
//     - The port and its counter are absent. All other behaviour is identical.
// TESTING
//   1. reset_i=1 for 2 cycles with random inputs -> bin_o=0, valid_o=0, err_o=0,
//      stable_o=0, stale_o=1.
//   2. Drive 16'h1234 muxed, 16 cycles per digit, order 0..3 ->
//      one valid_o pulse after the digit-3 capture, bin_o=16'h1234, stale_o=0.
//      Second identical frame -> stable_o=1.
//      Third frame 16'h1235 -> stable_o=0.
//   3. Hold each digit only SETTLE_CYCLES-1 cycles, with a 1-cycle all-off anode gap
//      (4'hF) between digits -> no capture, no valid_o, no err_o.
//   4. Digit 2 cathode=7'h7F settled -> err_o 1-cycle pulse; no valid_o that frame.
//      Next scan with a correct digit 2 -> valid_o.
//   5. TIMEOUT_BITS=6; after one frame hold anode=4'hF for 63 cycles -> stale_o=1,
//      stable_o=0, bin_o held.
//      Frame completing on the same cycle as the timeout -> valid_o=1, stale_o=0.
//   6. With SS_DECODER_ERR_CNT_EN: 3 invalid captures -> err_count_o=3;
//      300 invalid captures -> err_count_o=255.
//      Assert reset_i mid-frame -> err_count_o=0 and the partial frame is not reported.

Source files
------------

// File: rtl/ss_decoder.sv
// ss_decoder: recovers the hex value shown on a muxed active-low 7-segment bus.
// Optional SS_DECODER_ERR_CNT_EN adds err_count_o, a saturating decode-error count.
module ss_decoder #(
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT_BITS  = 20
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [3:0]  anode_bits_i,
  input  logic [6:0]  cathode_bits_i,
  output logic [15:0] bin_o,
  output logic        valid_o,
  output logic        stable_o,
  output logic        err_o,
  output logic        stale_o
`ifdef SS_DECODER_ERR_CNT_EN
  ,
  output logic [7:0]  err_count_o
`endif
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TIMEOUT_BITS-1:0] T_MAX = '1;
  localparam logic [CW-1:0] CNT_CAP = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURED
  } state_e;

  logic [3:0]  an_q, an_p_q;
  logic [6:0]  ca_q, ca_p_q;
  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  seen_q, seen_d;
  logic [15:0] shadow_q, shadow_d;
  logic        done_q, done_d;
  logic [TIMEOUT_BITS-1:0] timer_q, timer_d;
  logic [15:0] bin_q, bin_d;
  logic        valid_q, valid_d;
  logic        stable_q, stable_d;
  logic        err_q, err_d;
  logic        stale_q, stale_d;

  logic        samp_ok;
  logic        same;
  logic        cap;
  logic        timeout;
  logic [1:0]  dig;
  logic [4:0]  dec;
  logic        dec_ok;
  logic [3:0]  nib;

  function automatic logic [4:0] seg_dec(input logic [6:0] c);
    logic [4:0] r;
    r = 5'h00;
    case (c)
      7'h40: r = {1'b1, 4'h0};
      7'h79: r = {1'b1, 4'h1};
      7'h24: r = {1'b1, 4'h2};
      7'h30: r = {1'b1, 4'h3};
      7'h19: r = {1'b1, 4'h4};
      7'h12: r = {1'b1, 4'h5};
      7'h02: r = {1'b1, 4'h6};
      7'h78: r = {1'b1, 4'h7};
      7'h00: r = {1'b1, 4'h8};
      7'h10: r = {1'b1, 4'h9};
      7'h08: r = {1'b1, 4'hA};
      7'h03: r = {1'b1, 4'hB};
      7'h46: r = {1'b1, 4'hC};
      7'h21: r = {1'b1, 4'hD};
      7'h06: r = {1'b1, 4'hE};
      7'h0E: r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  assign samp_ok = $onehot(~an_q);
  assign same    = (an_q == an_p_q) && (ca_q == ca_p_q);
  assign dec     = seg_dec(ca_q);
  assign dec_ok  = dec[4];
  assign nib     = dec[3:0];

  always_comb begin
    dig = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!an_q[i]) dig = 2'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (samp_ok) begin
          state_d = SETTLE;
          cnt_d   = CW'(1);
        end
      end
      SETTLE: begin
        if (!samp_ok) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (same) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = CW'(1);
        end
      end
      CAPTURED: begin
        if (!samp_ok) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!same) begin
          state_d = SETTLE;
          cnt_d   = CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    cap = (state_d == SETTLE) && (cnt_d == CNT_CAP);
    if (cap) state_d = CAPTURED;
  end

  assign timeout = !cap && (timer_q == T_MAX - TIMEOUT_BITS'(1));

  always_comb begin
    seen_d   = seen_q;
    shadow_d = shadow_q;
    if (done_q || timeout) seen_d = '0;
    if (cap) begin
      seen_d[dig] = dec_ok;
      if (dec_ok) shadow_d[{dig, 2'b00} +: 4] = nib;
    end
    done_d = cap && dec_ok && (seen_d == 4'hF);
    err_d  = cap && !dec_ok;
  end

  // Completion outranks a coincident timeout, so the timer clears with it.
  always_comb begin
    timer_d = timer_q;
    if (cap) begin
      timer_d = '0;
    end else if (done_q && timeout) begin
      timer_d = '0;
    end else if (timer_q != T_MAX) begin
      timer_d = timer_q + TIMEOUT_BITS'(1);
    end
  end

  always_comb begin
    bin_d    = bin_q;
    valid_d  = 1'b0;
    stable_d = stable_q;
    stale_d  = stale_q;
    if (done_q) begin
      bin_d    = shadow_q;
      valid_d  = 1'b1;
      stale_d  = 1'b0;
      stable_d = (shadow_q == bin_q) && !stale_q;
    end else if (timeout) begin
      stale_d  = 1'b1;
      stable_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      an_q     <= '1;
      ca_q     <= '1;
      an_p_q   <= '1;
      ca_p_q   <= '1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      seen_q   <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
      timer_q  <= '0;
      bin_q    <= '0;
      valid_q  <= 1'b0;
      stable_q <= 1'b0;
      err_q    <= 1'b0;
      stale_q  <= 1'b1;
    end else begin
      an_q     <= anode_bits_i;
      ca_q     <= cathode_bits_i;
      an_p_q   <= an_q;
      ca_p_q   <= ca_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
      timer_q  <= timer_d;
      bin_q    <= bin_d;
      valid_q  <= valid_d;
      stable_q <= stable_d;
      err_q    <= err_d;
      stale_q  <= stale_d;
    end
  end

  assign bin_o    = bin_q;
  assign valid_o  = valid_q;
  assign stable_o = stable_q;
  assign err_o    = err_q;
  assign stale_o  = stale_q;

`ifdef SS_DECODER_ERR_CNT_EN
  logic [7:0] ecnt_q, ecnt_d;

  assign ecnt_d = (err_d && ecnt_q != 8'hFF) ? ecnt_q + 8'd1 : ecnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ecnt_q <= '0;
    end else begin
      ecnt_q <= ecnt_d;
    end
  end

  assign err_count_o = ecnt_q;
`endif

endmodule

// File: tb/tb_ss_decoder.sv
// tb_ss_decoder: random muxed display traffic against a hold-level reference model.
// Frames and decode errors are scoreboarded; state is checked at quiet checkpoints.
module tb_ss_decoder;

  localparam int SC   = 4;
  localparam int TB   = 6;
  localparam int TMAX = (1 << TB) - 1;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [3:0]  an;
  logic [6:0]  ca;
  logic [15:0] bin_o;
  logic        valid_o, stable_o, err_o, stale_o;
`ifdef SS_DECODER_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  always #5 clk = ~clk;

  ss_decoder #(
    .SETTLE_CYCLES(SC),
    .TIMEOUT_BITS (TB)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .anode_bits_i  (an),
    .cathode_bits_i(ca),
    .bin_o         (bin_o),
    .valid_o       (valid_o),
    .stable_o      (stable_o),
    .err_o         (err_o),
    .stale_o       (stale_o)
`ifdef SS_DECODER_ERR_CNT_EN
    ,
    .err_count_o   (err_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0]  seg_tab [16];
  logic [16:0] frame_q [$];
  bit          err_q   [$];

  int          me, last_cap, m_errs;
  bit          saturated, m_stale, m_stable;
  logic [3:0]  m_seen;
  logic [3:0]  m_sh [4];
  logic [15:0] m_bin;
  logic [3:0]  pa;
  logic [6:0]  pc;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit one_low(input logic [3:0] a);
    int n = 0;
    for (int i = 0; i < 4; i++) if (a[i] == 1'b0) n++;
    return n == 1;
  endfunction

  function automatic int low_idx(input logic [3:0] a);
    int r = 0;
    for (int i = 0; i < 4; i++) if (a[i] == 1'b0) r = i;
    return r;
  endfunction

  function automatic logic [4:0] ref_decode(input logic [6:0] c);
    for (int i = 0; i < 16; i++) begin
      if (seg_tab[i] == c) return {1'b1, 4'(i)};
    end
    return 5'h00;
  endfunction

  task automatic model_reset();
    me = 0; last_cap = 0; saturated = 0;
    m_stale = 1; m_stable = 0; m_seen = 0; m_bin = 0; m_errs = 0;
    for (int i = 0; i < 4; i++) m_sh[i] = 0;
  endtask

  // Timer runs out TMAX edges after the last capture with none in between.
  task automatic model_sync(input int e);
    if (!saturated && (e - last_cap) >= TMAX) begin
      saturated = 1;
      m_seen = 0;
      m_stale = 1;
      m_stable = 0;
    end
  endtask

  task automatic model_hold(input logic [3:0] a, input logic [6:0] c,
                            input int len);
    int ce, d;
    logic [4:0] dd;
    logic [15:0] nv;
    if (one_low(a) && len >= SC) begin
      ce = me + SC + 1;
      model_sync(ce - 1);
      last_cap = ce;
      saturated = 0;
      d = low_idx(a);
      dd = ref_decode(c);
      if (dd[4]) begin
        m_sh[d] = dd[3:0];
        m_seen[d] = 1'b1;
        if (m_seen == 4'hF) begin
          nv = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
          m_stable = (nv == m_bin) && !m_stale;
          m_bin = nv;
          m_stale = 0;
          m_seen = 0;
          frame_q.push_back({m_stable, nv});
        end
      end else begin
        m_seen[d] = 1'b0;
        err_q.push_back(1'b1);
        if (m_errs < 255) m_errs++;
      end
    end
    me += len;
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] c, input int len);
    if (one_low(a) && a == pa && c == pc) begin
      model_hold(4'hF, 7'h7F, 1);
      an = 4'hF;
      ca = 7'h7F;
      @(negedge clk);
    end
    model_hold(a, c, len);
    an = a;
    ca = c;
    pa = a;
    pc = c;
    repeat (len) @(negedge clk);
  endtask

  task automatic scan(input logic [15:0] v, input int len);
    logic [3:0] a;
    for (int d = 0; d < 4; d++) begin
      a = ~(4'(1) << d);
      hold(a, seg_tab[v[d*4 +: 4]], len);
    end
  endtask

  task automatic checkpoint(input string tag);
    #1;
    model_sync(me);
    check({tag, "_bin"}, 32'(bin_o), 32'(m_bin));
    check({tag, "_stale"}, 32'(stale_o), 32'(m_stale));
    check({tag, "_stable"}, 32'(stable_o), 32'(m_stable));
    check({tag, "_pending"}, frame_q.size() + err_q.size(), 0);
`ifdef SS_DECODER_ERR_CNT_EN
    check({tag, "_errcnt"}, 32'(err_count), 32'(m_errs));
`endif
  endtask

  task automatic do_reset(input bit chk);
    reset_i = 1'b1;
    an = 4'($urandom);
    ca = 7'($urandom);
    repeat (2) @(negedge clk);
    if (chk) begin
      check("rst_bin", 32'(bin_o), 0);
      check("rst_valid", 32'(valid_o), 0);
      check("rst_err", 32'(err_o), 0);
      check("rst_stable", 32'(stable_o), 0);
      check("rst_stale", 32'(stale_o), 1);
`ifdef SS_DECODER_ERR_CNT_EN
      check("rst_errcnt", 32'(err_count), 0);
`endif
    end
    frame_q.delete();
    err_q.delete();
    model_reset();
    reset_i = 1'b0;
    an = 4'hF;
    ca = 7'h7F;
    pa = 4'hF;
    pc = 7'h7F;
  endtask

  logic [16:0] fexp;

  always @(negedge clk) begin
    if (reset_i === 1'b0) begin
      if (valid_o === 1'b1) begin
        if (frame_q.size() == 0) begin
          check("valid_unexpected", 32'(bin_o), 32'hFFFF_FFFF);
        end else begin
          fexp = frame_q.pop_front();
          check("frame_bin", 32'(bin_o), 32'(fexp[15:0]));
          check("frame_stable", 32'(stable_o), 32'(fexp[16]));
          check("frame_stale", 32'(stale_o), 0);
        end
      end
      if (err_o === 1'b1) begin
        if (err_q.size() == 0) begin
          check("err_unexpected", 32'(err_o), 0);
        end else begin
          void'(err_q.pop_front());
          n_tests++;
        end
      end
    end
  end

  initial begin
    logic [3:0] a;
    logic [6:0] c;
    logic [15:0] v;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    reset_i = 1'b1;
    an = 4'hF;
    ca = 7'h7F;
    @(negedge clk);
    do_reset(1'b1);

    scan(16'h1234, 16);
    scan(16'h1234, 16);
    scan(16'h1235, 16);
    hold(4'hF, 7'h7F, 12);
    checkpoint("frames");

    for (int d = 0; d < 4; d++) begin
      a = ~(4'(1) << d);
      hold(a, seg_tab[d], SC - 1);
      hold(4'hF, 7'h7F, 1);
    end
    hold(4'hF, 7'h7F, 8);
    checkpoint("short");

    scan(16'hBEEF, 16);
    hold(4'hF, 7'h7F, 4);
    hold(4'hE, seg_tab[5], 16);
    hold(4'hD, seg_tab[6], 16);
    hold(4'hB, 7'h7F, 16);
    hold(4'h7, seg_tab[8], 16);
    hold(4'hF, 7'h7F, 8);
    checkpoint("blank");
    scan(16'h8765, 16);
    hold(4'hF, 7'h7F, 8);
    checkpoint("recover");

    hold(4'hF, 7'h7F, 70);
    checkpoint("stale");
    scan(16'h8765, 10);
    hold(4'hF, 7'h7F, 8);
    checkpoint("after_stale");

    for (int i = 0; i < 3; i++) begin
      hold(4'hE, 7'h7F, SC);
      hold(4'hD, 7'h7F, SC);
    end
    hold(4'hF, 7'h7F, 8);
    checkpoint("err6");
    for (int i = 0; i < 147; i++) begin
      hold(4'hE, 7'h7F, SC);
      hold(4'hD, 7'h7F, SC);
    end
    hold(4'hE, 7'h7F, SC);
    hold(4'hF, 7'h7F, 8);
    checkpoint("err300");

    hold(4'hE, seg_tab[1], 16);
    hold(4'hD, seg_tab[2], 16);
    do_reset(1'b0);
    checkpoint("midrst");
    hold(4'hB, seg_tab[3], 16);
    hold(4'h7, seg_tab[4], 16);
    hold(4'hF, 7'h7F, 8);
    checkpoint("partial");

    for (int k = 0; k < 160; k++) begin
      if ($urandom_range(0, 49) == 0) begin
        hold(4'hF, 7'h7F, 70);
      end else if ($urandom_range(0, 9) == 0) begin
        a = 4'($urandom);
        if (one_low(a)) a = 4'hF;
        hold(a, 7'($urandom), $urandom_range(1, 6));
      end else begin
        a = ~(4'(1) << $urandom_range(0, 3));
        v = 16'($urandom);
        c = seg_tab[v[3:0]];
        if ($urandom_range(0, 7) == 0) c = 7'($urandom);
        hold(a, c, $urandom_range(1, 20));
      end
    end
    hold(4'hF, 7'h7F, 12);
    checkpoint("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
